// File: rtl/tone_mixer.sv
// tone_mixer
//   Picks live or played-back keys from the recorder mode and runs one
//   square-wave oscillator per key. It sums the active oscillators into a
//   signed sample and hands that sample to the audio codec once per sample
//   slot, using a ready/write handshake.
//
// Ports
//   clock          system clock (single domain)
//   reset          asynchronous, active-low reset
//   mode[1:0]      recorder mode, 2'b10 = playback, anything else = live
//   keys[3:0]      live keys, active-high
//   playback_keys  recorder playback keys, active-high
//   write_ready    codec can take a sample this cycle
//   write          one-cycle strobe, samples valid while high
//   left_sample    signed 32-bit sample
//   right_sample   same value as left_sample
//   active_keys    registered selected keys (LEDs)
//   overrun_count  saturating count of dropped sample slots

// One square-wave oscillator. `on` is the registered enable. Its contribution
// to the mix therefore lines up with the cleared/reloaded counter and pol.
module tone_osc #(
    parameter int HALF_P = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic on,
    output logic pol
);
    localparam logic [19:0] RELOAD = 20'(HALF_P - 1);

    logic [19:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= RELOAD;
            pol <= 1'b0;
            on  <= 1'b0;
        end else begin
            on <= en;
            if (!en) begin
                cnt <= RELOAD;
                pol <= 1'b0;
            end else if (cnt == 20'd0) begin
                cnt <= RELOAD;
                pol <= ~pol;
            end else begin
                cnt <= cnt - 20'd1;
            end
        end
    end
endmodule

module tone_mixer #(
    parameter int HALF_P0    = 95556,
    parameter int HALF_P1    = 85131,
    parameter int HALF_P2    = 75843,
    parameter int HALF_P3    = 71586,
    parameter int AMP        = 10000000,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [3:0]  keys,
    input  logic [3:0]  playback_keys,
    input  logic        write_ready,
    output logic        write,
    output logic [31:0] left_sample,
    output logic [31:0] right_sample,
    output logic [3:0]  active_keys,
    output logic [7:0]  overrun_count
);
    localparam int NUM_KEYS = 4;
    localparam int DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic signed [31:0] AMP_S = 32'(AMP);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                state_q, state_d;
    logic [NUM_KEYS-1:0]   osc_on, osc_pol;
    logic signed [31:0]    mix_d, mix_q, held_q;
    logic [DIV_W-1:0]      div_q;
    logic                  tick;
    logic                  load_held, fire, ovr_inc;

    // Key select
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) active_keys <= '0;
        else        active_keys <= (mode == 2'b10) ? playback_keys : keys;
    end

    // Oscillators
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_osc
        localparam int HP = (i == 0) ? HALF_P0 :
                            (i == 1) ? HALF_P1 :
                            (i == 2) ? HALF_P2 : HALF_P3;
        tone_osc #(.HALF_P(HP)) u_osc (
            .clock (clock),
            .reset (reset),
            .en    (active_keys[i]),
            .on    (osc_on[i]),
            .pol   (osc_pol[i])
        );
    end

    // Mix: each enabled key adds +AMP (pol=1) or -AMP (pol=0)
    always_comb begin
        mix_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (osc_on[i]) mix_d = osc_pol[i] ? (mix_d + AMP_S) : (mix_d - AMP_S);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mix_q <= '0;
        else        mix_q <= mix_d;
    end

    // Slot divider
    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) div_q <= '0;
        else        div_q <= tick ? '0 : div_q + 1'b1;
    end

    // Output FSM
    always_comb begin
        state_d   = state_q;
        load_held = 1'b0;
        fire      = 1'b0;
        ovr_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    load_held = 1'b1;
                    state_d   = PENDING;
                end
            end
            PENDING: begin
                if (write_ready) begin
                    fire = 1'b1;
                    // A tick in the same cycle refills the slot, so this is
                    // not an overrun.
                    if (tick) load_held = 1'b1;
                    else      state_d   = IDLE;
                end else if (tick) begin
                    // Newest sample replaces the unsent one.
                    load_held = 1'b1;
                    ovr_inc   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            held_q        <= '0;
            write         <= 1'b0;
            left_sample   <= '0;
            right_sample  <= '0;
            overrun_count <= '0;
        end else begin
            state_q <= state_d;
            write   <= fire;
            if (load_held) held_q <= mix_q;
            if (fire) begin
                left_sample  <= held_q;
                right_sample <= held_q;
            end
            if (ovr_inc && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_tone_mixer.sv
module tb_tone_mixer;
    localparam int AMP = 100;
    localparam int DIV = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mode = '0;
    logic [3:0]  keys = '0;
    logic [3:0]  playback_keys = '0;
    logic        write_ready = 1'b0;
    logic        write;
    logic [31:0] left_sample, right_sample;
    logic [3:0]  active_keys;
    logic [7:0]  overrun_count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    tone_mixer #(
        .HALF_P0(4), .HALF_P1(5), .HALF_P2(6), .HALF_P3(7),
        .AMP(AMP), .SAMPLE_DIV(DIV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mode          (mode),
        .keys          (keys),
        .playback_keys (playback_keys),
        .write_ready   (write_ready),
        .write         (write),
        .left_sample   (left_sample),
        .right_sample  (right_sample),
        .active_keys   (active_keys),
        .overrun_count (overrun_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int half(input int i);
        case (i)
            0: return 4;
            1: return 5;
            2: return 6;
            default: return 7;
        endcase
    endfunction

    // Reference model. run[i] is the number of consecutive clock edges that
    // key i has been selected. The oscillator phase follows directly from it:
    // the key is sounding once run >= 1, and it is high on odd multiples of
    // the half-period.
    logic [3:0] m_act;
    int         m_run [4];
    int         m_mix, m_cyc, m_held, m_samp, m_ovr;
    bit         m_pend, m_wr;

    always @(posedge clock or negedge reset) begin : model
        int  nm;
        bit  tk;
        if (!reset) begin
            m_act = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_mix = 0; m_cyc = 0; m_held = 0; m_samp = 0; m_ovr = 0;
            m_pend = 0; m_wr = 0;
        end else begin
            nm = 0;
            for (int i = 0; i < 4; i++)
                if (m_run[i] >= 1) nm += (((m_run[i] / half(i)) % 2) == 1) ? AMP : -AMP;
            for (int i = 0; i < 4; i++) m_run[i] = m_act[i] ? m_run[i] + 1 : 0;
            m_act = (mode == 2'b10) ? playback_keys : keys;
            tk = ((m_cyc % DIV) == DIV - 1);
            m_cyc++;
            m_wr = m_pend && write_ready;
            if (m_wr) m_samp = m_held;
            if (!m_pend) begin
                if (tk) begin m_held = m_mix; m_pend = 1; end
            end else if (write_ready) begin
                m_pend = tk;
                if (tk) m_held = m_mix;
            end else if (tk) begin
                m_held = m_mix;
                if (m_ovr < 255) m_ovr++;
            end
            m_mix = nm;
        end
    end

    always @(negedge clock) begin
        if (reset && chk_on) begin
            check("write", write, m_wr);
            check("left_sample", $signed(left_sample), m_samp);
            check("right_sample", $signed(right_sample), m_samp);
            check("active_keys", active_keys, m_act);
            check("overrun_count", overrun_count, m_ovr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reset at a negedge and release at the next negedge, so the following
    // posedge is edge 1 after release.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] keys;
        logic [3:0] pb;
        logic [3:0] exp_act;
    } vec_t;

    vec_t vt [7];
    int   nwr;
    bit   found;

    initial begin
        vt[0] = '{mode: 2'b00, keys: 4'b0001, pb: 4'b0100, exp_act: 4'b0001};
        vt[1] = '{mode: 2'b10, keys: 4'b0001, pb: 4'b0100, exp_act: 4'b0100};
        vt[2] = '{mode: 2'b01, keys: 4'b0101, pb: 4'b1010, exp_act: 4'b0101};
        vt[3] = '{mode: 2'b11, keys: 4'b1001, pb: 4'b0110, exp_act: 4'b1001};
        vt[4] = '{mode: 2'b10, keys: 4'b1111, pb: 4'b0011, exp_act: 4'b0011};
        vt[5] = '{mode: 2'b00, keys: 4'b1111, pb: 4'b0000, exp_act: 4'b1111};
        vt[6] = '{mode: 2'b00, keys: 4'b0000, pb: 4'b1111, exp_act: 4'b0000};

        // Reset state
        cyc(2);
        check("rst_write", write, 0);
        check("rst_left", left_sample, 0);
        check("rst_right", right_sample, 0);
        check("rst_active", active_keys, 0);
        check("rst_overrun", overrun_count, 0);
        chk_on = 1'b1;

        // Chord held from reset, codec always ready
        keys = 4'b1111; write_ready = 1'b1;
        do_reset();
        cyc(80);

        // Key select table
        for (int v = 0; v < 7; v++) begin
            mode = vt[v].mode; keys = vt[v].keys; playback_keys = vt[v].pb;
            cyc(1);
            check("tbl_active_keys", active_keys, vt[v].exp_act);
            cyc(40);
        end

        // Backpressure: three ticks without ready, then one write
        keys = 4'b0011; mode = 2'b00; write_ready = 1'b0;
        do_reset();
        cyc(48);
        write_ready = 1'b1;
        cyc(1);
        check("bp_write", write, 1);
        check("bp_overrun", overrun_count, 2);
        nwr = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1);
            if (write) nwr++;
        end
        check("bp_single_write", nwr, 0);

        // Ready rises in a tick cycle while pending
        keys = 4'b0110; write_ready = 1'b0;
        do_reset();
        cyc(31);
        write_ready = 1'b1;
        cyc(1);
        check("sim_write", write, 1);
        check("sim_overrun", overrun_count, 0);
        cyc(1);
        check("sim_write_again", write, 1);
        cyc(1);
        check("sim_write_drop", write, 0);

        // Randomized phase
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(19, 0) == 0) begin
                keys          = 4'($urandom);
                playback_keys = 4'($urandom);
                mode          = 2'($urandom);
            end
            write_ready = ($urandom_range(3, 0) != 0);
            cyc(1);
        end

        // Reset mid-pending with all keys held
        keys = 4'b1111; mode = 2'b00; write_ready = 1'b0;
        cyc(20);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_write", write, 0);
        check("mid_rst_left", left_sample, 0);
        check("mid_rst_right", right_sample, 0);
        check("mid_rst_active", active_keys, 0);
        check("mid_rst_overrun", overrun_count, 0);
        keys = 4'b0000; write_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (write) found = 1'b1;
        end
        check("post_rst_write_seen", found, 1);
        check("post_rst_sample", $signed(left_sample), 0);

        // Saturation of the overrun counter
        keys = 4'b0001; write_ready = 1'b0;
        cyc(300 * DIV);
        check("ovr_saturate", overrun_count, 255);
        write_ready = 1'b1;
        cyc(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
